// File: rtl/completion_pkg.sv
// rtl/completion_pkg.sv - shared types and defaults for the completion reorder buffer
// Holds default widths/depths, functional-unit index constants and the ROB entry type.
package completion_pkg;

    localparam int DEF_DISPATCH_W = 2;
    localparam int DEF_NUM_FU     = 3;
    localparam int DEF_ROB_DEPTH  = 8;
    localparam int DEF_RETIRE_W   = 2;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_TAG_W      = 8;
    localparam int DEF_PC_W       = 16;
    localparam int DEF_NUM_REGS   = 4;
    localparam int DEF_REG_W      = $clog2(DEF_NUM_REGS);

    // Result bus indices; a lower index wins when two buses carry the same tag.
    localparam int FU_LOAD = 0;
    localparam int FU_MULT = 1;
    localparam int FU_ADD  = 2;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  exc;
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_REG_W-1:0]  dest;
        logic [DEF_PC_W-1:0]   pc;
        logic [DEF_DATA_W-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/completion_regfile.sv
// rtl/completion_regfile.sv - architectural register file with per-retire-slot write ports
// Ports: clk_i, rst_ni (async active-low), we_i/waddr_i/wdata_i one write port per
// retirement slot (higher slot = younger instruction), regs_o flattened register contents.
module completion_regfile
    import completion_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RETIRE_W = DEF_RETIRE_W,
    localparam int REG_W   = $clog2(NUM_REGS)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [RETIRE_W-1:0]        we_i,
    input  logic [RETIRE_W*REG_W-1:0]  waddr_i,
    input  logic [RETIRE_W*DATA_W-1:0] wdata_i,
    output logic [NUM_REGS*DATA_W-1:0] regs_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Ports applied oldest first so the youngest write to a register lands last.
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < RETIRE_W; p++) begin
            if (we_i[p]) begin
                regs_d[waddr_i[p*REG_W +: REG_W]] = wdata_i[p*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_out
        assign regs_o[r*DATA_W +: DATA_W] = regs_q[r];
    end

endmodule

// File: rtl/completion_rob.sv
// rtl/completion_rob.sv - in-order completion reorder buffer with precise exceptions
// Ports: clk, rst_n (async active-low); disp_* dispatch slots (slot 0 oldest) and stall;
// fu_* result buses; reg_out architectural registers; ret_* registered retirement report;
// exc_* registered precise exception report.
module completion_rob
    import completion_pkg::*;
#(
    parameter int DISPATCH_W = DEF_DISPATCH_W,
    parameter int NUM_FU     = DEF_NUM_FU,
    parameter int ROB_DEPTH  = DEF_ROB_DEPTH,
    parameter int RETIRE_W   = DEF_RETIRE_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int TAG_W      = DEF_TAG_W,
    parameter int PC_W       = DEF_PC_W,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    localparam int REG_W     = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DISPATCH_W-1:0]        disp_valid,
    input  logic [DISPATCH_W*TAG_W-1:0]  disp_tag,
    input  logic [DISPATCH_W*REG_W-1:0]  disp_dest,
    input  logic [DISPATCH_W*PC_W-1:0]   disp_pc,
    output logic                         stall,
    input  logic [NUM_FU-1:0]            fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]      fu_tag,
    input  logic [NUM_FU*DATA_W-1:0]     fu_data,
    input  logic [NUM_FU-1:0]            fu_exc,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    output logic [RETIRE_W-1:0]          ret_valid,
    output logic [RETIRE_W*TAG_W-1:0]    ret_tag,
    output logic [RETIRE_W*DATA_W-1:0]   ret_data,
    output logic                         exc_valid,
    output logic [PC_W-1:0]              exc_pc,
    output logic [TAG_W-1:0]             exc_tag
);

    localparam int IDX_W = $clog2(ROB_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(ROB_DEPTH);
    localparam logic [PTR_W-1:0] DISP_P  = PTR_W'(DISPATCH_W);

    rob_entry_t rob_q [ROB_DEPTH];
    rob_entry_t rob_d [ROB_DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, count;
    logic [PTR_W-1:0] nret, disp_off;
    logic [IDX_W-1:0] ridx, didx;
    logic             flush, wb_hit, ret_go;

    logic [RETIRE_W-1:0]        ret_valid_q, ret_valid_d;
    logic [RETIRE_W*TAG_W-1:0]  ret_tag_q, ret_tag_d;
    logic [RETIRE_W*DATA_W-1:0] ret_data_q, ret_data_d;
    logic                       exc_valid_q, exc_valid_d;
    logic [PC_W-1:0]            exc_pc_q, exc_pc_d;
    logic [TAG_W-1:0]           exc_tag_q, exc_tag_d;

    logic [RETIRE_W-1:0]        rf_we;
    logic [RETIRE_W*REG_W-1:0]  rf_waddr;
    logic [RETIRE_W*DATA_W-1:0] rf_wdata;

    // Pointers carry a wrap bit, so the difference is the occupancy even when full.
    assign count = tail_q - head_q;
    assign stall = (DEPTH_P - count) < DISP_P;

    always_comb begin
        rob_d       = rob_q;
        head_d      = head_q;
        tail_d      = tail_q;
        flush       = 1'b0;
        wb_hit      = 1'b0;
        ret_go      = 1'b1;
        nret        = '0;
        disp_off    = '0;
        ridx        = '0;
        didx        = '0;
        rf_we       = '0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        ret_valid_d = '0;
        ret_tag_d   = '0;
        ret_data_d  = '0;
        exc_valid_d = 1'b0;
        exc_pc_d    = '0;
        exc_tag_d   = '0;

        // Writeback matches only entries already in the buffer; lowest FU index wins.
        for (int e = 0; e < ROB_DEPTH; e++) begin
            wb_hit = 1'b0;
            if (rob_q[e].valid && !rob_q[e].done) begin
                for (int f = 0; f < NUM_FU; f++) begin
                    if (!wb_hit && fu_valid[f] && (fu_tag[f*TAG_W +: TAG_W] == rob_q[e].tag)) begin
                        wb_hit         = 1'b1;
                        rob_d[e].done  = 1'b1;
                        rob_d[e].exc   = fu_exc[f];
                        rob_d[e].data  = fu_data[f*DATA_W +: DATA_W];
                    end
                end
            end
        end

        // Retire a consecutive run of done entries from head. An excepting entry
        // stops the run and is only acted on once it is itself the head.
        for (int i = 0; i < RETIRE_W; i++) begin
            ridx = head_q[IDX_W-1:0] + IDX_W'(i);
            if (ret_go && (count > PTR_W'(i)) && rob_q[ridx].valid && rob_q[ridx].done) begin
                if (rob_q[ridx].exc) begin
                    ret_go = 1'b0;
                    if (i == 0) begin
                        flush       = 1'b1;
                        exc_valid_d = 1'b1;
                        exc_pc_d    = rob_q[ridx].pc;
                        exc_tag_d   = rob_q[ridx].tag;
                    end
                end else begin
                    rob_d[ridx].valid                 = 1'b0;
                    ret_valid_d[i]                    = 1'b1;
                    ret_tag_d[i*TAG_W +: TAG_W]       = rob_q[ridx].tag;
                    ret_data_d[i*DATA_W +: DATA_W]    = rob_q[ridx].data;
                    rf_we[i]                          = 1'b1;
                    rf_waddr[i*REG_W +: REG_W]        = rob_q[ridx].dest;
                    rf_wdata[i*DATA_W +: DATA_W]      = rob_q[ridx].data;
                    nret                              = nret + PTR_W'(1);
                end
            end else begin
                ret_go = 1'b0;
            end
        end
        head_d = head_q + nret;

        // Valid slots are packed into consecutive entries at tail.
        if (!stall && !flush) begin
            for (int s = 0; s < DISPATCH_W; s++) begin
                if (disp_valid[s]) begin
                    didx              = tail_q[IDX_W-1:0] + disp_off[IDX_W-1:0];
                    rob_d[didx].valid = 1'b1;
                    rob_d[didx].done  = 1'b0;
                    rob_d[didx].exc   = 1'b0;
                    rob_d[didx].tag   = disp_tag[s*TAG_W +: TAG_W];
                    rob_d[didx].dest  = disp_dest[s*REG_W +: REG_W];
                    rob_d[didx].pc    = disp_pc[s*PC_W +: PC_W];
                    rob_d[didx].data  = '0;
                    disp_off          = disp_off + PTR_W'(1);
                end
            end
        end
        tail_d = tail_q + disp_off;

        // Exception at head discards everything, including this cycle's writebacks.
        if (flush) begin
            for (int e = 0; e < ROB_DEPTH; e++) begin
                rob_d[e].valid = 1'b0;
            end
            head_d = tail_q;
            tail_d = tail_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < ROB_DEPTH; e++) begin
                rob_q[e] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            ret_valid_q <= '0;
            ret_tag_q   <= '0;
            ret_data_q  <= '0;
            exc_valid_q <= 1'b0;
            exc_pc_q    <= '0;
            exc_tag_q   <= '0;
        end else begin
            rob_q       <= rob_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            ret_valid_q <= ret_valid_d;
            ret_tag_q   <= ret_tag_d;
            ret_data_q  <= ret_data_d;
            exc_valid_q <= exc_valid_d;
            exc_pc_q    <= exc_pc_d;
            exc_tag_q   <= exc_tag_d;
        end
    end

    assign ret_valid = ret_valid_q;
    assign ret_tag   = ret_tag_q;
    assign ret_data  = ret_data_q;
    assign exc_valid = exc_valid_q;
    assign exc_pc    = exc_pc_q;
    assign exc_tag   = exc_tag_q;

    completion_regfile #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .RETIRE_W (RETIRE_W)
    ) u_regfile (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .we_i    (rf_we),
        .waddr_i (rf_waddr),
        .wdata_i (rf_wdata),
        .regs_o  (reg_out)
    );

endmodule

// File: tb/tb_completion_rob.sv
// tb/tb_completion_rob.sv - directed self-checking bench for completion_rob
module tb_completion_rob;

    logic         clk;
    logic         rst_n;
    logic [1:0]   disp_valid;
    logic [15:0]  disp_tag;
    logic [3:0]   disp_dest;
    logic [31:0]  disp_pc;
    logic         stall;
    logic [2:0]   fu_valid;
    logic [23:0]  fu_tag;
    logic [95:0]  fu_data;
    logic [2:0]   fu_exc;
    logic [127:0] reg_out;
    logic [1:0]   ret_valid;
    logic [15:0]  ret_tag;
    logic [63:0]  ret_data;
    logic         exc_valid;
    logic [15:0]  exc_pc;
    logic [7:0]   exc_tag;

    int total = 0;
    int bad   = 0;

    completion_rob dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .disp_valid (disp_valid),
        .disp_tag   (disp_tag),
        .disp_dest  (disp_dest),
        .disp_pc    (disp_pc),
        .stall      (stall),
        .fu_valid   (fu_valid),
        .fu_tag     (fu_tag),
        .fu_data    (fu_data),
        .fu_exc     (fu_exc),
        .reg_out    (reg_out),
        .ret_valid  (ret_valid),
        .ret_tag    (ret_tag),
        .ret_data   (ret_data),
        .exc_valid  (exc_valid),
        .exc_pc     (exc_pc),
        .exc_tag    (exc_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        disp_valid = '0;
        disp_tag   = '0;
        disp_dest  = '0;
        disp_pc    = '0;
        fu_valid   = '0;
        fu_tag     = '0;
        fu_data    = '0;
        fu_exc     = '0;
    endtask

    task automatic dsp(input int s, input logic [7:0] tag, input logic [1:0] dest, input logic [15:0] pc);
        disp_valid[s]        = 1'b1;
        disp_tag[s*8 +: 8]   = tag;
        disp_dest[s*2 +: 2]  = dest;
        disp_pc[s*16 +: 16]  = pc;
    endtask

    task automatic wb(input int f, input logic [7:0] tag, input logic [31:0] data, input logic exc);
        fu_valid[f]          = 1'b1;
        fu_tag[f*8 +: 8]     = tag;
        fu_data[f*32 +: 32]  = data;
        fu_exc[f]            = exc;
    endtask

    task automatic chk_regs(input string name, input logic [31:0] r0, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [31:0] r3);
        chk({name, "_r0"}, reg_out[31:0],   r0);
        chk({name, "_r1"}, reg_out[63:32],  r1);
        chk({name, "_r2"}, reg_out[95:64],  r2);
        chk({name, "_r3"}, reg_out[127:96], r3);
    endtask

    initial begin
        logic [7:0] t;
        rst_n = 1'b0;
        clr();
        tick();
        tick();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_ret_valid", {30'd0, ret_valid}, 32'd0);
        chk("rst_ret_tag", {16'd0, ret_tag}, 32'd0);
        chk("rst_exc_valid", {31'd0, exc_valid}, 32'd0);
        chk("rst_exc_pc", {16'd0, exc_pc}, 32'd0);
        chk("rst_exc_tag", {24'd0, exc_tag}, 32'd0);
        chk_regs("rst", 32'h0, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic in-order completion of two instructions.
        clr(); dsp(0, 8'h40, 2'd1, 16'h0012); dsp(1, 8'h30, 2'd0, 16'h0022);
        tick();
        clr(); wb(0, 8'h40, 32'h23232323, 1'b0); wb(1, 8'h30, 32'h000006e8, 1'b0);
        tick();
        chk("basic_no_early_ret", {30'd0, ret_valid}, 32'd0);
        clr();
        tick();
        chk("basic_ret_valid", {30'd0, ret_valid}, 32'd3);
        chk("basic_ret_tag0", {24'd0, ret_tag[7:0]}, 32'h40);
        chk("basic_ret_tag1", {24'd0, ret_tag[15:8]}, 32'h30);
        chk("basic_ret_data0", ret_data[31:0], 32'h23232323);
        chk("basic_ret_data1", ret_data[63:32], 32'h000006e8);
        chk_regs("basic", 32'h6e8, 32'h23232323, 32'h0, 32'h0);
        tick();
        chk("basic_ret_pulse", {30'd0, ret_valid}, 32'd0);

        // Younger add completes before older mult.
        clr(); dsp(0, 8'h20, 2'd3, 16'h0030); dsp(1, 8'h21, 2'd2, 16'h0032);
        tick();
        clr(); wb(2, 8'h21, 32'h55, 1'b0);
        tick();
        clr();
        tick();
        chk("ooo_hold", {30'd0, ret_valid}, 32'd0);
        wb(1, 8'h20, 32'h77, 1'b0);
        tick();
        clr();
        tick();
        chk("ooo_ret_valid", {30'd0, ret_valid}, 32'd3);
        chk("ooo_ret_tag0", {24'd0, ret_tag[7:0]}, 32'h20);
        chk("ooo_ret_tag1", {24'd0, ret_tag[15:8]}, 32'h21);
        chk("ooo_ret_data0", ret_data[31:0], 32'h77);
        chk_regs("ooo", 32'h6e8, 32'h23232323, 32'h55, 32'h77);

        // Same dest retired twice in one cycle; two FUs carrying one tag.
        clr(); dsp(0, 8'h10, 2'd2, 16'h0040); dsp(1, 8'h11, 2'd2, 16'h0042);
        tick();
        clr(); wb(0, 8'h10, 32'h5555, 1'b0); wb(1, 8'h10, 32'h9999, 1'b0); wb(2, 8'h11, 32'haaaa, 1'b0);
        tick();
        clr();
        tick();
        chk("waw_ret_valid", {30'd0, ret_valid}, 32'd3);
        chk("fu_prio_data0", ret_data[31:0], 32'h5555);
        chk("waw_reg2", reg_out[95:64], 32'haaaa);

        // Exception at head: flush, pulse, same-cycle dispatch discarded.
        clr(); dsp(0, 8'h41, 2'd1, 16'h0028); dsp(1, 8'h42, 2'd0, 16'h002a);
        tick();
        clr(); wb(0, 8'h41, 32'hdead, 1'b1); wb(2, 8'h42, 32'h1234, 1'b0);
        tick();
        clr(); dsp(0, 8'h50, 2'd1, 16'h0040);
        tick();
        chk("exc_valid", {31'd0, exc_valid}, 32'd1);
        chk("exc_pc", {16'd0, exc_pc}, 32'h0028);
        chk("exc_tag", {24'd0, exc_tag}, 32'h41);
        chk("exc_no_ret", {30'd0, ret_valid}, 32'd0);
        clr(); wb(0, 8'h50, 32'hbeef, 1'b0); wb(1, 8'h42, 32'h1, 1'b0);
        tick();
        chk("exc_pulse", {31'd0, exc_valid}, 32'd0);
        clr();
        tick();
        chk("exc_flushed_no_ret", {30'd0, ret_valid}, 32'd0);
        chk("exc_stall", {31'd0, stall}, 32'd0);
        chk_regs("exc", 32'h6e8, 32'h23232323, 32'haaaa, 32'h77);

        // Exception behind a retiring older entry waits one cycle.
        clr(); dsp(0, 8'h60, 2'd3, 16'h0050); dsp(1, 8'h61, 2'd0, 16'h0052);
        tick();
        clr(); wb(0, 8'h60, 32'h11, 1'b0); wb(1, 8'h61, 32'h22, 1'b1);
        tick();
        clr();
        tick();
        chk("exc2_ret_valid", {30'd0, ret_valid}, 32'd1);
        chk("exc2_ret_tag0", {24'd0, ret_tag[7:0]}, 32'h60);
        chk("exc2_not_yet", {31'd0, exc_valid}, 32'd0);
        tick();
        chk("exc2_valid", {31'd0, exc_valid}, 32'd1);
        chk("exc2_pc", {16'd0, exc_pc}, 32'h0052);
        chk("exc2_tag", {24'd0, exc_tag}, 32'h61);
        chk_regs("exc2", 32'h6e8, 32'h23232323, 32'haaaa, 32'h11);
        tick();

        // Fill toward full and watch stall.
        clr(); dsp(0, 8'h80, 2'd0, 16'h0); dsp(1, 8'h81, 2'd0, 16'h0);
        tick(); chk("full_stall_2", {31'd0, stall}, 32'd0);
        clr(); dsp(0, 8'h82, 2'd0, 16'h0); dsp(1, 8'h83, 2'd0, 16'h0);
        tick(); chk("full_stall_4", {31'd0, stall}, 32'd0);
        clr(); dsp(0, 8'h84, 2'd0, 16'h0); dsp(1, 8'h85, 2'd0, 16'h0);
        tick(); chk("full_stall_6", {31'd0, stall}, 32'd0);
        clr(); dsp(0, 8'h86, 2'd0, 16'h0);
        tick(); chk("full_stall_7", {31'd0, stall}, 32'd1);
        clr(); dsp(0, 8'h87, 2'd0, 16'h0); dsp(1, 8'h88, 2'd0, 16'h0);
        tick(); chk("full_stalled_ignored", {31'd0, stall}, 32'd1);
        clr(); wb(0, 8'h80, 32'h80, 1'b0);
        tick();
        clr();
        tick();
        chk("full_ret80", {24'd0, ret_tag[7:0]}, 32'h80);
        chk("full_ret80_valid", {30'd0, ret_valid}, 32'd1);
        chk("full_stall_6b", {31'd0, stall}, 32'd0);
        clr(); dsp(0, 8'h87, 2'd0, 16'h0); dsp(1, 8'h88, 2'd0, 16'h0);
        tick(); chk("full_stall_8", {31'd0, stall}, 32'd1);
        clr(); wb(0, 8'h81, 32'h81, 1'b0);
        tick();
        clr();
        tick(); chk("full_stall_7b", {31'd0, stall}, 32'd1);
        clr(); wb(0, 8'h82, 32'h82, 1'b0);
        tick();
        clr();
        tick(); chk("full_stall_6c", {31'd0, stall}, 32'd0);
        clr(); wb(0, 8'h83, 32'h83, 1'b0);
        tick();
        clr(); wb(0, 8'h85, 32'h85, 1'b0);
        tick();
        chk("pre_rst_ret83", {24'd0, ret_tag[7:0]}, 32'h83);
        chk("pre_rst_ret_valid", {30'd0, ret_valid}, 32'd1);

        // Reset with five entries in flight.
        clr();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ret_valid", {30'd0, ret_valid}, 32'd0);
        chk("mid_rst_exc_valid", {31'd0, exc_valid}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk_regs("mid_rst", 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        rst_n = 1'b1;
        wb(0, 8'h84, 32'h84, 1'b0);
        tick();
        chk("post_rst_ret_a", {30'd0, ret_valid}, 32'd0);
        clr();
        tick();
        chk("post_rst_ret_b", {30'd0, ret_valid}, 32'd0);
        chk("post_rst_exc", {31'd0, exc_valid}, 32'd0);

        // Three full laps to exercise pointer wrap.
        for (int lap = 0; lap < 3; lap++) begin
            for (int k = 0; k < 4; k++) begin
                clr();
                t = 8'(8'h90 + lap*8 + 2*k);
                dsp(0, t, 2'((2*k) % 4), 16'(t));
                dsp(1, t + 8'd1, 2'((2*k+1) % 4), 16'(t + 8'd1));
                tick();
                chk("lap_stall", {31'd0, stall}, (k == 3) ? 32'd1 : 32'd0);
            end
            for (int k = 0; k < 4; k++) begin
                clr();
                t = 8'(8'h90 + lap*8 + 2*k);
                wb(0, t, 32'h1000_0000 | 32'(t), 1'b0);
                wb(1, t + 8'd1, 32'h1000_0000 | 32'(t + 8'd1), 1'b0);
                tick();
                if (k > 0) begin
                    chk("lap_ret_valid", {30'd0, ret_valid}, 32'd3);
                    chk("lap_ret_tag0", {24'd0, ret_tag[7:0]}, 32'(8'h90 + lap*8 + 2*(k-1)));
                    chk("lap_ret_data1", ret_data[63:32], 32'h1000_0000 | 32'(8'h90 + lap*8 + 2*(k-1) + 1));
                end
            end
            clr();
            tick();
            chk("lap_ret_last", {24'd0, ret_tag[15:8]}, 32'(8'h90 + lap*8 + 7));
            tick();
            chk("lap_idle", {30'd0, ret_valid}, 32'd0);
            chk("lap_empty_stall", {31'd0, stall}, 32'd0);
        end
        chk_regs("laps", 32'h100000a4, 32'h100000a5, 32'h100000a6, 32'h100000a7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/completion_rob.md
COMPLETION_ROB -- requirements
Module: completion_rob

Interface
REQ-001 Parameter DISPATCH_W, default 2, instructions dispatched per cycle.
REQ-002 Parameter NUM_FU, default 3, result buses (0 load, 1 mult, 2 add).
REQ-003 Parameter ROB_DEPTH, default 8, entries; power of two, >= 2*DISPATCH_W.
REQ-004 Parameter RETIRE_W, default 2, max retirements per cycle.
REQ-005 Parameters DATA_W 32, TAG_W 8, PC_W 16, NUM_REGS 4 (REG_W = log2 NUM_REGS).
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 disp_valid  in  DISPATCH_W  per-slot dispatch request; slot 0 oldest.
REQ-009 disp_tag  in  DISPATCH_W*TAG_W  per-slot instruction tag.
REQ-010 disp_dest  in  DISPATCH_W*REG_W  per-slot destination register.
REQ-011 disp_pc  in  DISPATCH_W*PC_W  per-slot PC.
REQ-012 stall  out  1  dispatch not accepted this cycle.
REQ-013 fu_valid / fu_tag / fu_data / fu_exc  in  NUM_FU / NUM_FU*TAG_W / NUM_FU*DATA_W / NUM_FU  result buses.
REQ-014 reg_out  out  NUM_REGS*DATA_W  architectural register file contents.
REQ-015 ret_valid / ret_tag / ret_data  out  RETIRE_W / RETIRE_W*TAG_W / RETIRE_W*DATA_W  retirement report, slot 0 oldest.
REQ-016 exc_valid / exc_pc / exc_tag  out  1 / PC_W / TAG_W  precise exception report.

Function
REQ-017 Circular buffer, head/tail pointers with extra wrap bit; count = tail - head, full when count == ROB_DEPTH.
REQ-018 stall = (ROB_DEPTH - count) < DISPATCH_W, from registered state only (no dependence on same-cycle retire).
REQ-019 stall=0: all valid slots written at tail in slot order, tail advances by popcount(disp_valid); stall=1: no slot accepted.
REQ-020 Valid slots are packed; gaps (slot1 valid, slot0 not) still allocate in order, invalid slots skipped.
REQ-021 Writeback: fu_valid with tag matching a valid, not-done entry sets done, stores fu_data and fu_exc at the edge.
REQ-022 Unmatched or already-done tags ignored; tag dispatched same cycle is not yet matchable; multiple FUs same tag, lowest FU index wins.
REQ-023 Retire: starting at head, up to RETIRE_W consecutive done, non-exc entries retire per cycle; stops at first not-done entry.
REQ-024 Retired entries write reg_out[dest] at the edge (visible next cycle); same dest twice in one cycle, younger wins.
REQ-025 ret_* registered: ret_valid[i] pulses one cycle with tag/data of i-th retired entry; unused slots ret_valid=0.
REQ-026 Exception only when the done exc entry is at head after older entries retired (entry behind a retiring older one waits one cycle).
REQ-027 Exception at head: no reg write for it; exc_valid pulses one cycle next cycle with its pc and tag; whole ROB flushed (head=tail, all invalid); same-cycle dispatch and writebacks discarded.
REQ-028 Tags in flight are unique; duplicate dispatch of a live tag is a source error, behaviour undefined.
REQ-029 Latency: dispatch edge N, writeback edge >= N+1, earliest retire edge N+2.

Reset
REQ-030 rst_n low: all entries invalid, head=tail=0, reg_out=0, ret_valid=0, ret_tag/ret_data=0, exc_valid=0, exc_pc=0, exc_tag=0; stall=0 once deasserted.
REQ-031 Reset mid-operation discards all in-flight entries; no retire or exception reported for them.

Structure
REQ-032 Package completion_pkg holds entry typedef (valid, done, exc, tag, dest, pc, data), FU index constants, defaults.
REQ-033 One sub-module completion_regfile: NUM_REGS x DATA_W, RETIRE_W write ports with younger-wins priority.

Verification
REQ-034 Dispatch 0x40 dest1 pc0x12 and 0x30 dest0 pc0x22; load 0x40 data 0x23232323, mult 0x30 data 0x6e8 -> ret both next cycle, reg1=0x23232323, reg0=0x6e8.
REQ-035 Out-of-order: add 0x21 completes before mult 0x20 (older) -> no retire until 0x20 done, then both same cycle, 0x20 in slot 0.
REQ-036 Page fault: load 0x41 fu_exc=1 at head, pc0x28 -> exc_valid one cycle, exc_pc=0x0028, exc_tag=0x41, ROB empty, later writebacks ignored, regs unchanged.
REQ-037 Full: 8 dispatches without writeback -> stall=1 when 7 occupied (DISPATCH_W=2), one retire frees one slot, stall stays 1 until two free.
REQ-038 Two retires to dest 2 same cycle (0x10 then 0x11 data 0xaaaa) -> reg2=0xaaaa.
REQ-039 rst_n low with 5 in flight -> all outputs zero, no ret/exc pulses, pointers wrap correctly after 3 further full laps.
